// File: rtl/fp16_pipe_arbiter_pkg.sv
// Shared widths, requester ids and the round-robin pick for the fp16 unit arbiter.
`ifndef FP16_WIDTH
`define FP16_WIDTH 16
`endif
`ifndef FP16_ARB_NREQ
`define FP16_ARB_NREQ 2
`endif
`ifndef FP16_ARB_ID_WIDTH
`define FP16_ARB_ID_WIDTH 1
`endif

package fp16_pipe_arbiter_pkg;

    localparam int FP16_W = `FP16_WIDTH;
    localparam int ID_W   = `FP16_ARB_ID_WIDTH;

    typedef logic [FP16_W-1:0] fp16_t;

    typedef enum logic [ID_W-1:0] {
        REQ0 = ID_W'(0),
        REQ1 = ID_W'(1)
    } req_id_e;

    // One entry of the ownership pipeline that travels alongside an operation.
    typedef struct packed {
        logic    valid;
        req_id_e id;
    } tag_t;

    // Picks the requester to serve; on contention the one not served last wins.
    function automatic req_id_e rr_pick(input logic elig0, input logic elig1,
                                        input req_id_e last_id);
        if (elig0 && elig1) begin
            return (last_id == REQ0) ? REQ1 : REQ0;
        end else if (elig1) begin
            return REQ1;
        end else begin
            return REQ0;
        end
    endfunction

endpackage

// File: rtl/fp16_rsp_fifo.sv
// First-word-fall-through response FIFO that also reports its occupancy.
module fp16_rsp_fifo
    import fp16_pipe_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  fp16_t                  push_data,
    input  logic                   pop,
    output fp16_t                  head,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    fp16_t            mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             do_pop;

    assign do_pop = pop && !empty;
    assign head   = mem[rptr];
    assign empty  = (count == '0);

    // Storage, wrapping pointers and occupancy; a push and a pop in one cycle both happen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= push_data;
                wptr      <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            if (push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp16_pipe_arbiter.sv
// Shares one fixed-latency fp16 unit between two requesters with credit-based response FIFOs.
module fp16_pipe_arbiter
    import fp16_pipe_arbiter_pkg::*;
#(
    parameter int LATENCY   = 4,
    parameter int RSP_DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_req0_valid,
    output logic                   o_req0_ready,
    input  logic [`FP16_WIDTH-1:0] i_req0_a,
    input  logic [`FP16_WIDTH-1:0] i_req0_b,
    input  logic                   i_req1_valid,
    output logic                   o_req1_ready,
    input  logic [`FP16_WIDTH-1:0] i_req1_a,
    input  logic [`FP16_WIDTH-1:0] i_req1_b,
    output logic                   o_op_valid,
    output logic [`FP16_WIDTH-1:0] o_op_a,
    output logic [`FP16_WIDTH-1:0] o_op_b,
    input  logic [`FP16_WIDTH-1:0] i_res_data,
    output logic                   o_rsp0_valid,
    input  logic                   i_rsp0_ready,
    output logic [`FP16_WIDTH-1:0] o_rsp0_data,
    output logic                   o_rsp1_valid,
    input  logic                   i_rsp1_ready,
    output logic [`FP16_WIDTH-1:0] o_rsp1_data,
    output logic                   o_busy
);

    localparam int               CNT_W   = $clog2(RSP_DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RSP_DEPTH);

    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;
    logic [CNT_W-1:0] occ0;
    logic [CNT_W-1:0] occ1;
    logic             elig0;
    logic             elig1;
    logic             grant0;
    logic             grant1;
    logic             wr0;
    logic             wr1;
    logic             pop0;
    logic             pop1;
    logic             empty0;
    logic             empty1;
    logic             inflight;
    req_id_e          last_id;
    req_id_e          pick_id;
    tag_t             tag_pipe [0:LATENCY];

    // A requester holding all of its credits must wait; the credit count already
    // covers every result that could still land in its FIFO, so no result is dropped.
    assign elig0   = i_rst_n && i_req0_valid && (cnt0 < CNT_MAX);
    assign elig1   = i_rst_n && i_req1_valid && (cnt1 < CNT_MAX);
    assign pick_id = rr_pick(elig0, elig1, last_id);
    assign grant0  = elig0 && (pick_id == REQ0);
    assign grant1  = elig1 && (pick_id == REQ1);

    assign o_req0_ready = grant0;
    assign o_req1_ready = grant1;

    assign wr0  = tag_pipe[LATENCY].valid && (tag_pipe[LATENCY].id == REQ0);
    assign wr1  = tag_pipe[LATENCY].valid && (tag_pipe[LATENCY].id == REQ1);
    assign pop0 = o_rsp0_valid && i_rsp0_ready;
    assign pop1 = o_rsp1_valid && i_rsp1_ready;

    assign o_rsp0_valid = !empty0;
    assign o_rsp1_valid = !empty1;

    // Registers the granted operand pair into the unit and remembers who was served.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_op_valid <= 1'b0;
            o_op_a     <= '0;
            o_op_b     <= '0;
            last_id    <= REQ1;
        end else if (grant0) begin
            o_op_valid <= 1'b1;
            o_op_a     <= i_req0_a;
            o_op_b     <= i_req0_b;
            last_id    <= REQ0;
        end else if (grant1) begin
            o_op_valid <= 1'b1;
            o_op_a     <= i_req1_a;
            o_op_b     <= i_req1_b;
            last_id    <= REQ1;
        end else begin
            o_op_valid <= 1'b0;
        end
    end

    // Ownership tags ride alongside the unit so the last stage lines up with i_res_data.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i <= LATENCY; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0] <= '{valid: (grant0 || grant1), id: (grant1 ? REQ1 : REQ0)};
            for (int i = 1; i <= LATENCY; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    // Per-requester credits: taken on issue, returned when the response is consumed.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (grant0 && !pop0) begin
                cnt0 <= cnt0 + 1'b1;
            end else if (!grant0 && pop0) begin
                cnt0 <= cnt0 - 1'b1;
            end
            if (grant1 && !pop1) begin
                cnt1 <= cnt1 + 1'b1;
            end else if (!grant1 && pop1) begin
                cnt1 <= cnt1 - 1'b1;
            end
        end
    end

    // Anything still travelling through the unit keeps the block busy.
    always_comb begin
        inflight = 1'b0;
        for (int i = 0; i <= LATENCY; i++) begin
            inflight = inflight | tag_pipe[i].valid;
        end
    end

    assign o_busy = inflight || (occ0 != '0) || (occ1 != '0);

    fp16_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_rsp0_fifo (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .push      (wr0),
        .push_data (i_res_data),
        .pop       (pop0),
        .head      (o_rsp0_data),
        .empty     (empty0),
        .count     (occ0)
    );

    fp16_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_rsp1_fifo (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .push      (wr1),
        .push_data (i_res_data),
        .pop       (pop1),
        .head      (o_rsp1_data),
        .empty     (empty1),
        .count     (occ1)
    );

endmodule

// File: tb/tb_fp16_pipe_arbiter.sv
// Directed bench for fp16_pipe_arbiter with an XOR stand-in for the shared fp16 unit.
module tb_fp16_pipe_arbiter;

    localparam int LATENCY   = 4;
    localparam int RSP_DEPTH = 4;

    logic        clk;
    logic        rstN;
    logic        req0Valid, req0Ready, req1Valid, req1Ready;
    logic [15:0] req0A, req0B, req1A, req1B;
    logic        opValid;
    logic [15:0] opA, opB, resData;
    logic        rsp0Valid, rsp0Ready, rsp1Valid, rsp1Ready;
    logic [15:0] rsp0Data, rsp1Data;
    logic        busy;

    int          totalChecks = 0;
    int          badChecks   = 0;
    int          cycleCount  = 0;

    int          hs0Cycle[$], hs1Cycle[$], rsp0Cycle[$], rsp1Cycle[$], grantLog[$];
    logic [15:0] exp0[$], exp1[$], got0[$], got1[$];
    int          out0, out1, maxOut0, maxOut1;
    int          wrong;

    fp16_pipe_arbiter #(.LATENCY(LATENCY), .RSP_DEPTH(RSP_DEPTH)) dut (
        .i_clk        (clk),
        .i_rst_n      (rstN),
        .i_req0_valid (req0Valid),
        .o_req0_ready (req0Ready),
        .i_req0_a     (req0A),
        .i_req0_b     (req0B),
        .i_req1_valid (req1Valid),
        .o_req1_ready (req1Ready),
        .i_req1_a     (req1A),
        .i_req1_b     (req1B),
        .o_op_valid   (opValid),
        .o_op_a       (opA),
        .o_op_b       (opB),
        .i_res_data   (resData),
        .o_rsp0_valid (rsp0Valid),
        .i_rsp0_ready (rsp0Ready),
        .o_rsp0_data  (rsp0Data),
        .o_rsp1_valid (rsp1Valid),
        .i_rsp1_ready (rsp1Ready),
        .o_rsp1_data  (rsp1Data),
        .o_busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Stand-in unit: a LATENCY-deep delay line of a ^ b, never reset, so stale data keeps flowing.
    logic [15:0] unitPipe [LATENCY];
    always @(posedge clk) begin
        unitPipe[0] <= opA ^ opB;
        for (int i = 1; i < LATENCY; i++) unitPipe[i] <= unitPipe[i-1];
    end
    assign resData = unitPipe[LATENCY-1];

    // Scoreboard: logs handshakes and consumed responses and tracks outstanding credits.
    always @(negedge clk) begin
        if (rstN) begin
            if (req0Valid && req0Ready) begin
                hs0Cycle.push_back(cycleCount);
                exp0.push_back(req0A ^ req0B);
                grantLog.push_back(0);
                out0 = out0 + 1;
            end
            if (req1Valid && req1Ready) begin
                hs1Cycle.push_back(cycleCount);
                exp1.push_back(req1A ^ req1B);
                grantLog.push_back(1);
                out1 = out1 + 1;
            end
            if (rsp0Valid && rsp0Ready) begin
                got0.push_back(rsp0Data);
                rsp0Cycle.push_back(cycleCount);
                out0 = out0 - 1;
            end
            if (rsp1Valid && rsp1Ready) begin
                got1.push_back(rsp1Data);
                rsp1Cycle.push_back(cycleCount);
                out1 = out1 - 1;
            end
            if (out0 > maxOut0) maxOut0 = out0;
            if (out1 > maxOut1) maxOut1 = out1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalChecks++;
        if (got !== exp) begin
            badChecks++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic [15:0] a0, input logic [15:0] b0,
                                 input logic v1, input logic [15:0] a1, input logic [15:0] b1,
                                 input logic r0, input logic r1);
        req0Valid = v0; req0A = a0; req0B = b0;
        req1Valid = v1; req1A = a1; req1B = b1;
        rsp0Ready = r0; rsp1Ready = r1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearLogs();
        hs0Cycle.delete(); hs1Cycle.delete(); rsp0Cycle.delete(); rsp1Cycle.delete();
        grantLog.delete(); exp0.delete(); exp1.delete(); got0.delete(); got1.delete();
        out0 = 0; out1 = 0; maxOut0 = 0; maxOut1 = 0;
    endtask

    task automatic doReset();
        rstN = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
        tick();
        tick();
        rstN = 1'b1;
        clearLogs();
    endtask

    initial begin
        // Reset state, with both requesters already asking.
        rstN = 1'b0;
        clearLogs();
        applyStimulus(1, 16'h1234, 16'h5678, 1, 16'h9ABC, 16'hDEF0, 1, 1);
        #2;
        checkOutput("rst_ready0", req0Ready, 0);
        checkOutput("rst_ready1", req1Ready, 0);
        checkOutput("rst_op_valid", opValid, 0);
        checkOutput("rst_op_a", opA, 0);
        checkOutput("rst_op_b", opB, 0);
        checkOutput("rst_rsp0_valid", rsp0Valid, 0);
        checkOutput("rst_rsp1_valid", rsp1Valid, 0);
        checkOutput("rst_busy", busy, 0);

        // Single operation on requester 0: 0x3C00 ^ 0x0001 comes back LATENCY+2 cycles later.
        doReset();
        applyStimulus(1, 16'h3C00, 16'h0001, 0, 0, 0, 1, 1);
        @(negedge clk);
        checkOutput("t1_ready0", req0Ready, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
        @(negedge clk);
        checkOutput("t1_op_valid", opValid, 1);
        checkOutput("t1_op_a", opA, 16'h3C00);
        checkOutput("t1_op_b", opB, 16'h0001);
        repeat (12) tick();
        checkOutput("t1_rsp0_count", got0.size(), 1);
        if (got0.size() > 0 && hs0Cycle.size() > 0) begin
            checkOutput("t1_rsp0_data", got0[0], 16'h3C01);
            checkOutput("t1_latency", rsp0Cycle[0] - hs0Cycle[0], LATENCY + 2);
        end
        checkOutput("t1_rsp1_count", got1.size(), 0);
        checkOutput("t1_busy_idle", busy, 0);

        // Contention: both stream, grants must alternate starting with requester 0.
        doReset();
        applyStimulus(1, 16'h4000, 16'h0000, 1, 16'hC000, 16'h0000, 1, 1);
        repeat (8) tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
        repeat (12) tick();
        checkOutput("t2_grant_count", grantLog.size(), 8);
        wrong = 0;
        foreach (grantLog[i]) if (grantLog[i] != (i % 2)) wrong++;
        checkOutput("t2_alternation", wrong, 0);
        checkOutput("t2_rsp0_count", got0.size(), 4);
        checkOutput("t2_rsp1_count", got1.size(), 4);
        wrong = 0;
        foreach (got0[i]) if (got0[i] != 16'h4000) wrong++;
        foreach (got1[i]) if (got1[i] != 16'hC000) wrong++;
        checkOutput("t2_routing", wrong, 0);

        // Backpressure on response 0 while requester 1 keeps going.
        doReset();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, 16'h1000, 16'(i), 1, 16'h2000, 16'(16'h0100 + i), 0, 1);
            tick();
        end
        @(negedge clk);
        checkOutput("t3_hs0_count", hs0Cycle.size(), RSP_DEPTH);
        checkOutput("t3_ready0_stall", req0Ready, 0);
        checkOutput("t3_rsp0_held", rsp0Valid, 1);
        checkOutput("t3_req1_progress", hs1Cycle.size() >= 8, 1);
        tick();
        applyStimulus(1, 16'h1000, 16'h0055, 0, 0, 0, 0, 1);
        repeat (12) tick();
        checkOutput("t3_rsp1_count", got1.size(), hs1Cycle.size());
        wrong = 0;
        foreach (got1[i]) if (i < exp1.size() && got1[i] != exp1[i]) wrong++;
        checkOutput("t3_rsp1_order", wrong, 0);

        // Pop at full credit: ready stays low this cycle, credit is usable next cycle.
        applyStimulus(1, 16'h1000, 16'h0055, 0, 0, 0, 1, 1);
        @(negedge clk);
        checkOutput("t4_ready_same_cycle", req0Ready, 0);
        checkOutput("t4_rsp0_pop", rsp0Valid, 1);
        tick();
        applyStimulus(1, 16'h1000, 16'h0066, 0, 0, 0, 0, 1);
        @(negedge clk);
        checkOutput("t4_credit_freed", req0Ready, 1);
        tick();
        @(negedge clk);
        checkOutput("t4_recapped", req0Ready, 0);

        // Drain and resume streaming on requester 0.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 16'h1000, 16'(16'h0200 + i), 0, 0, 0, 1, 1);
            tick();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
        repeat (15) tick();
        checkOutput("t3_resumed", hs0Cycle.size() >= 8, 1);
        checkOutput("t3_rsp0_count", got0.size(), hs0Cycle.size());
        wrong = 0;
        foreach (got0[i]) if (i < exp0.size() && got0[i] != exp0[i]) wrong++;
        checkOutput("t3_rsp0_order", wrong, 0);
        checkOutput("t3_credit_bound0", maxOut0 <= RSP_DEPTH, 1);
        checkOutput("t3_credit_bound1", maxOut1 <= RSP_DEPTH, 1);
        checkOutput("t3_busy_idle", busy, 0);

        // Reset with three operations in flight: nothing stale may come out afterwards.
        doReset();
        applyStimulus(1, 16'h3C00, 16'h0001, 0, 0, 0, 1, 1);
        repeat (3) tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
        tick();
        checkOutput("t5_busy_before", busy, 1);
        rstN = 1'b0;
        applyStimulus(1, 16'h3C00, 16'h0001, 1, 16'h4000, 16'h0000, 1, 1);
        #1;
        checkOutput("t5_op_valid", opValid, 0);
        checkOutput("t5_ready0", req0Ready, 0);
        checkOutput("t5_rsp0_valid", rsp0Valid, 0);
        checkOutput("t5_rsp1_valid", rsp1Valid, 0);
        checkOutput("t5_busy_in_reset", busy, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1);
        tick();
        rstN = 1'b1;
        clearLogs();
        repeat (12) tick();
        checkOutput("t5_no_stale_rsp0", got0.size(), 0);
        checkOutput("t5_no_stale_rsp1", got1.size(), 0);
        checkOutput("t5_busy_after", busy, 0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
